register_array_loader: RTL and testbench

Sequencer for the 16-entry, 32-bit parallel register array. Fills a staging bank from a serial valid/ready word stream, commits the full bank with a single-cycle write enable, and streams array contents back out serially on request. Sits between the serial bus-side producer/consumer and the array's parallel `data_in`/`write_en`/`data_out` ports.

---
 rtl/register_array_loader.sv | 88 ++++++++
 tb/tb_register_array_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_array_loader.sv
// register_array_loader: stages a serial word stream into a parallel register array,
// commits it with a one-cycle write enable, and streams the array back out serially.
module register_array_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         unload_start,
    input  logic                         abort,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEPTH-1:0][WIDTH-1:0]  arr_data_in,
    output logic                         arr_write_en,
    input  logic [DEPTH-1:0][WIDTH-1:0]  arr_data_out,
    output logic                         busy,
    output logic                         done
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, UNLOAD} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          in_hs, out_hs, done_nx;

    always_comb begin
        in_ready     = state == LOAD;
        out_valid    = state == UNLOAD;
        arr_write_en = state == COMMIT;
        busy         = state != IDLE;
        in_hs        = in_ready && in_valid;
        out_hs       = out_valid && out_ready;
        out_data     = arr_data_out[idx];
        state_nx     = state;
        idx_nx       = idx;
        done_nx      = 1'b0;
        case (state)
            IDLE:   state_nx = load_start ? LOAD : unload_start ? UNLOAD : IDLE;
            LOAD: begin
                if (abort) state_nx = IDLE;
                else if (in_hs) begin
                    idx_nx   = idx + 1'b1;
                    state_nx = idx == LAST ? COMMIT : LOAD;
                end
            end
            COMMIT: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            UNLOAD: begin
                if (abort) state_nx = IDLE;
                else if (out_hs) begin
                    idx_nx   = idx + 1'b1;
                    state_nx = idx == LAST ? IDLE : UNLOAD;
                    done_nx  = idx == LAST;
                end
            end
            default: state_nx = IDLE;
        endcase
        // every path into IDLE restarts the index so the next transfer begins at entry 0
        if (state_nx == IDLE) idx_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            done  <= done_nx;
        end
    end

    // a word accepted in the same cycle as abort is still staged, just never committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arr_data_in <= '0;
        else if (in_hs) arr_data_in[idx] <= in_data;
    end
endmodule

// File: tb/tb_register_array_loader.sv
// tb_register_array_loader: scoreboard bench with a behavioural register array model.
module tb_register_array_loader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    typedef logic [DEPTH-1:0][WIDTH-1:0] bank_t;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              load_start = 0, unload_start = 0, abort = 0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_valid = 0, out_ready = 0;
    logic              in_ready, out_valid, arr_write_en, busy, done;
    logic [WIDTH-1:0]  out_data;
    bank_t             arr_data_in, arr;
    logic              arr_ok = 0;

    int n_vec = 0, n_fail = 0, we_cnt = 0, done_cnt = 0, exp_done = 0;
    logic [WIDTH-1:0] out_q[$];
    bank_t            bank_q[$];

    register_array_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .unload_start(unload_start),
        .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .arr_data_in(arr_data_in), .arr_write_en(arr_write_en), .arr_data_out(arr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // array model: preset pattern, then captures the staging bank on write enable
    always @(posedge clk) begin
        if (arr_write_en === 1'b1) arr <= arr_data_in;
        else if (!arr_ok) for (int i = 0; i < DEPTH; i++) arr[i] <= 32'hDEAD_0000 + i;
    end

    always @(posedge clk) begin
        if (arr_write_en === 1'b1) we_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [DEPTH*WIDTH-1:0] act, input logic [DEPTH*WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (out_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL out_extra: got %0h expected no word", out_data);
            end else check("out_word", out_data, out_q.pop_front());
        end
        if (arr_write_en === 1'b1) begin
            if (bank_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL commit_extra: got write enable expected none");
            end else check("commit_bank", arr_data_in, bank_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] base, input bit thr, input int abort_at,
                           input bit abort_commit, input bit both);
        int n = 0, g = 0, we0 = we_cnt;
        logic acc;
        bank_t b;
        for (int i = 0; i < DEPTH; i++) b[i] = base + i;
        if (abort_at < 0) begin
            bank_q.push_back(b);
            exp_done++;
        end
        load_start = 1; unload_start = both;
        step();
        load_start = 0; unload_start = 0;
        check("load_entry_ready", in_ready, 1);
        check("load_entry_no_out", out_valid, 0);
        while (n < DEPTH && g < 100) begin
            if (n == abort_at) break;
            in_valid = !thr || (g % 2 == 0);
            in_data = in_valid ? base + n : 32'hBAD0_0000 + n;
            unload_start = both && n == 4;
            acc = in_valid && in_ready;
            step();
            g++;
            if (acc) n++;
        end
        in_valid = 0; unload_start = 0;
        if (abort_at >= 0) begin
            abort = 1;
            step();
            abort = 0;
            check("abort_idle", busy, 0);
            check("abort_no_done", done, 0);
            check("abort_no_we", we_cnt, we0);
            return;
        end
        check("load_words", n, DEPTH);
        if (!thr) check("load_cycles", g, DEPTH);
        check("commit_we", arr_write_en, 1);
        check("commit_not_ready", in_ready, 0);
        abort = abort_commit;
        step();
        abort = 0;
        check("load_done", done, 1);
        check("load_idle", busy, 0);
        check("we_once", we_cnt, we0 + 1);
        check("arr_first", arr[0], base);
        check("arr_last", arr[DEPTH-1], base + DEPTH - 1);
    endtask

    task automatic do_unload(input logic [31:0] base, input bit stall);
        int n = 0, g = 0, s = 0;
        logic hs;
        for (int i = 0; i < DEPTH; i++) out_q.push_back(base + i);
        exp_done++;
        unload_start = 1;
        step();
        unload_start = 0;
        check("unload_first_valid", out_valid, 1);
        while (n < DEPTH && g < 100) begin
            if (stall && n == 7 && s < 3) begin
                out_ready = 0;
                s++;
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, base + 7);
            end else out_ready = 1;
            hs = out_valid && out_ready;
            step();
            g++;
            if (hs) n++;
        end
        out_ready = 0;
        check("unload_words", n, DEPTH);
        if (!stall) check("unload_cycles", g, DEPTH);
        check("unload_done", done, 1);
        check("unload_idle", busy, 0);
    endtask

    initial begin
        int we0;
        step(); step();
        arr_ok = 1;
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_we", arr_write_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 32'hDEAD_0000);
        rst_n = 1;
        step();

        // reset in the middle of a load after 5 words
        we0 = we_cnt;
        load_start = 1;
        step();
        load_start = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h7777_0000 + i;
            step();
        end
        rst_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_staging", arr_data_in, 0);
        check("mid_rst_out_data", out_data, 32'hDEAD_0000);
        in_valid = 0;
        step();
        rst_n = 1;
        step();
        check("mid_rst_no_we", we_cnt, we0);
        check("mid_rst_arr", arr[3], 32'hDEAD_0003);

        do_load(32'h1000_0000, 0, -1, 0, 0);
        step();
        check("done_one_cycle", done, 0);
        do_unload(32'h1000_0000, 1);
        step();

        do_load(32'h2000_0000, 1, -1, 0, 0);
        step();

        we0 = we_cnt;
        do_load(32'h3000_0000, 0, 9, 0, 0);
        step(); step();
        check("abort_keeps_arr", arr[0], 32'h2000_0000);
        check("abort_keeps_we", we_cnt, we0);

        do_load(32'h4000_0000, 0, -1, 1, 0);
        step();

        do_load(32'h5000_0000, 0, -1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_queued_unload", out_valid, 0);
        end

        do_load(32'hA5A5_0000, 0, -1, 0, 0);
        do_unload(32'hA5A5_0000, 0);
        step(); step();

        check("out_queue_empty", out_q.size(), 0);
        check("bank_queue_empty", bank_q.size(), 0);
        check("done_total", done_cnt, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
